// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the 1:N fabric: opcode constants and FSM encoding.
package tl_pkg;

  localparam logic [3:0] TL_PUT_FULL = 4'd0;
  localparam logic [3:0] TL_PUT_PART = 4'd1;
  localparam logic [3:0] TL_GET      = 4'd4;
  localparam logic [3:0] TL_ACK      = 4'd0;
  localparam logic [3:0] TL_ACK_DATA = 4'd1;

  typedef enum logic [1:0] {
    StIdle,
    StAreq,
    StDwait,
    StResp
  } xbar_state_e;

  // D opcode the fabric itself generates when it answers a request (miss or timeout).
  function automatic logic [3:0] ack_opcode(input logic [3:0] a_opcode);
    return (a_opcode == TL_GET) ? TL_ACK_DATA : TL_ACK;
  endfunction

endpackage

// File: rtl/tl_addr_dec.sv
// Address decoder: the top SELW address bits pick a slave; values >= NSLV are a miss.
module tl_addr_dec #(
  parameter int unsigned AW   = 8,
  parameter int unsigned SELW = 2,
  parameter int unsigned NSLV = 4
) (
  input  logic [AW-1:0]   addr_i,
  output logic [SELW-1:0] sel_o,
  output logic            miss_o
);

  // Slaves decode their own offset bits; only the select field matters here.
  logic unused_addr;

  always_comb begin
    sel_o       = addr_i[AW-1 -: SELW];
    miss_o      = (32'(sel_o) >= NSLV);
    unused_addr = ^addr_i[AW-SELW-1:0];
  end

endmodule

// File: rtl/tl_xbar_1n.sv
// 1-master/N-slave TileLink-UL fabric with a single outstanding transaction,
// decode-miss and timeout error responses.
module tl_xbar_1n
  import tl_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 8,
  parameter int unsigned NSLV = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned TMO  = 64
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 m_a_valid,
  output logic                 m_a_ready,
  input  logic [3:0]           m_a_opcode,
  input  logic [DW/8-1:0]      m_a_mask,
  input  logic [AW-1:0]        m_a_address,
  input  logic [DW-1:0]        m_a_data,

  output logic                 m_d_valid,
  input  logic                 m_d_ready,
  output logic [3:0]           m_d_opcode,
  output logic [DW-1:0]        m_d_data,
  output logic                 m_d_error,

  output logic [NSLV-1:0]      s_a_valid,
  input  logic [NSLV-1:0]      s_a_ready,
  output logic [3:0]           s_a_opcode,
  output logic [DW/8-1:0]      s_a_mask,
  output logic [AW-1:0]        s_a_address,
  output logic [DW-1:0]        s_a_data,

  input  logic [NSLV-1:0]      s_d_valid,
  output logic [NSLV-1:0]      s_d_ready,
  input  logic [4*NSLV-1:0]    s_d_opcode,
  input  logic [DW*NSLV-1:0]   s_d_data
);

  localparam int unsigned MW   = DW / 8;
  localparam int unsigned CntW = $clog2(TMO);

  xbar_state_e state_q, state_d;

  logic [3:0]      req_op_q;
  logic [MW-1:0]   req_mask_q;
  logic [AW-1:0]   req_addr_q;
  logic [DW-1:0]   req_data_q;
  logic [SELW-1:0] sel_q;
  logic [CntW-1:0] cnt_q;

  logic [3:0]      rsp_op_q;
  logic [DW-1:0]   rsp_data_q;
  logic            rsp_err_q;

  logic [SELW-1:0] dec_sel;
  logic            dec_miss;

  logic [NSLV-1:0] sel_oh;
  logic [3:0]      sel_d_opcode;
  logic [DW-1:0]   sel_d_data;
  logic            a_hit;
  logic            d_hit;
  logic            tmo_hit;

  tl_addr_dec #(
    .AW   (AW),
    .SELW (SELW),
    .NSLV (NSLV)
  ) u_addr_dec (
    .addr_i (m_a_address),
    .sel_o  (dec_sel),
    .miss_o (dec_miss)
  );

  // Route the selected slave's handshakes and response fields.
  always_comb begin
    sel_oh       = '0;
    sel_d_opcode = '0;
    sel_d_data   = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q == SELW'(k)) begin
        sel_oh[k]    = 1'b1;
        sel_d_opcode = s_d_opcode[4*k +: 4];
        sel_d_data   = s_d_data[DW*k +: DW];
      end
    end
    a_hit   = |(s_a_ready & sel_oh);
    d_hit   = |(s_d_valid & sel_oh);
    tmo_hit = (cnt_q == CntW'(TMO - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a handshake is checked before the timeout so it always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m_a_valid) state_d = dec_miss ? StResp : StAreq;
      end
      StAreq: begin
        if (a_hit)        state_d = StDwait;
        else if (tmo_hit) state_d = StResp;
      end
      StDwait: begin
        if (d_hit || tmo_hit) state_d = StResp;
      end
      StResp: begin
        if (m_d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_op_q   <= '0;
      req_mask_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      rsp_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (m_a_valid) begin
            req_op_q   <= m_a_opcode;
            req_mask_q <= m_a_mask;
            req_addr_q <= m_a_address;
            req_data_q <= m_a_data;
            sel_q      <= dec_sel;
            cnt_q      <= '0;
            if (dec_miss) begin
              rsp_op_q   <= ack_opcode(m_a_opcode);
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        StAreq: begin
          if (a_hit) begin
            cnt_q <= '0;
          end else if (tmo_hit) begin
            rsp_op_q   <= ack_opcode(req_op_q);
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDwait: begin
          if (d_hit) begin
            rsp_op_q   <= sel_d_opcode;
            // Acks without data return zero regardless of what the slave drives.
            rsp_data_q <= (sel_d_opcode == TL_ACK_DATA) ? sel_d_data : '0;
            rsp_err_q  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_op_q   <= ack_opcode(req_op_q);
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; in IDLE every slave may drain stray responses.
  always_comb begin
    m_a_ready   = (state_q == StIdle);
    m_d_valid   = (state_q == StResp);
    m_d_opcode  = rsp_op_q;
    m_d_data    = rsp_data_q;
    m_d_error   = rsp_err_q;
    s_a_valid   = (state_q == StAreq) ? sel_oh : '0;
    s_a_opcode  = req_op_q;
    s_a_mask    = req_mask_q;
    s_a_address = req_addr_q;
    s_a_data    = req_data_q;
    s_d_ready   = '0;
    if (state_q == StIdle)       s_d_ready = '1;
    else if (state_q == StDwait) s_d_ready = sel_oh;
  end

endmodule
